// File: rtl/prefix_adder_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : prefix_adder_pipe_if
// Brief   : Operand/result stream bundle for the pipelined prefix adder.
// Revision: 1.0 - initial release
// ============================================================================
interface prefix_adder_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             in_chain;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, in_chain, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, in_chain, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );
endinterface
`default_nettype wire

// File: rtl/prefix_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module  : prefix_adder_pipe
// Brief   : Pipelined Kogge-Stone adder/subtractor with cross-beat carry chain.
// Revision: 1.0 - initial release
// ============================================================================
module prefix_adder_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  wire logic            clk,
   input  wire logic            rst,
   prefix_adder_pipe_if.slave   io
);
   localparam int LEVELS = $clog2(WIDTH);
   localparam int NREG   = (STAGES > 1) ? STAGES - 1 : 1;

   typedef struct packed {
      logic             sub;
      logic             chain;
      logic             cin;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] pp;
   } beat_t;

   // Spread STAGES-1 inner cuts evenly over prefix levels 0..LEVELS-1.
   function automatic bit is_cut(input int lvl);
      return ((lvl + 1) * STAGES) / (LEVELS + 1) != (lvl * STAGES) / (LEVELS + 1);
   endfunction

   logic            en_w;
   beat_t           stage_q [NREG];
   beat_t           stage_d [NREG];
   logic [NREG-1:0] vld_q;
   logic [NREG-1:0] vld_d;
   beat_t           fin_w;
   logic            fin_vld_w;
   logic            out_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic            cout_q;
   logic            ovf_q;
   logic            chain_q;
   logic            chain_d;
   logic            cin_eff_w;
   logic [WIDTH:0]  c_w;

   assign en_w         = ~out_valid_q | io.out_ready;
   assign io.in_ready  = en_w;
   assign io.out_valid = out_valid_q;
   assign io.out_sum   = sum_q;
   assign io.out_cout  = cout_q;
   assign io.out_ovf   = ovf_q;

   always_comb begin : prefix_net
      beat_t            cur;
      beat_t            nxt;
      logic             cur_vld;
      logic [WIDTH-1:0] bx;
      int               k;
      int               d;
      stage_d   = stage_q;
      vld_d     = vld_q;
      bx        = io.in_sub ? ~io.in_b : io.in_b;
      cur.sub   = io.in_sub;
      cur.chain = io.in_chain;
      cur.cin   = io.in_cin;
      cur.p     = io.in_a ^ bx;
      cur.g     = io.in_a & bx;
      cur.pp    = io.in_a ^ bx;
      cur_vld   = io.in_valid;
      k         = 0;
      for (int l = 1; l <= LEVELS; l++) begin
         if (is_cut(l - 1)) begin
            stage_d[k] = cur;
            vld_d[k]   = cur_vld;
            cur        = stage_q[k];
            cur_vld    = vld_q[k];
            k          = k + 1;
         end
         d   = 1 << (l - 1);
         nxt = cur;
         for (int i = d; i < WIDTH; i++) begin
            nxt.g[i]  = cur.g[i] | (cur.pp[i] & cur.g[i-d]);
            nxt.pp[i] = cur.pp[i] & cur.pp[i-d];
         end
         cur = nxt;
      end
      fin_w     = cur;
      fin_vld_w = cur_vld;
   end

   // The beat entering the output register sees the carry of the beat leaving it.
   always_comb begin : carry_resolve
      chain_d   = (out_valid_q & io.out_ready) ? cout_q : chain_q;
      cin_eff_w = fin_w.chain ? chain_d : (fin_w.sub | fin_w.cin);
      c_w[0]    = cin_eff_w;
      for (int i = 1; i <= WIDTH; i++) begin
         c_w[i] = fin_w.g[i-1] | (fin_w.pp[i-1] & cin_eff_w);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q       <= '0;
         out_valid_q <= 1'b0;
         chain_q     <= 1'b0;
      end else begin
         chain_q <= chain_d;
         if (en_w) begin
            vld_q       <= vld_d;
            out_valid_q <= fin_vld_w;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (en_w) begin
         stage_q <= stage_d;
         sum_q   <= fin_w.p ^ c_w[WIDTH-1:0];
         cout_q  <= c_w[WIDTH];
         ovf_q   <= c_w[WIDTH] ^ c_w[WIDTH-1];
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_prefix_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_prefix_adder_pipe
// Brief   : Scoreboard bench for prefix_adder_pipe (WIDTH=8, STAGES=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_prefix_adder_pipe;
   localparam int W = 8;
   localparam int S = 2;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   prefix_adder_pipe_if #(.WIDTH(W)) io ();
   prefix_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .io(io));

   exp_t         sb [$];
   int           n_vec = 0;
   int           n_fail = 0;
   logic         chain_m = 1'b0;
   int           rdy_mode = 0;
   bit           stall_seen = 1'b0;
   bit           prev_hold = 1'b0;
   logic [W-1:0] prev_sum;
   logic         prev_cout;
   logic         prev_ovf;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Consumer readiness: 0 = always ready, 1 = random stalls, 2 = held off.
   always begin
      case (rdy_mode)
         0:       io.out_ready = 1'b1;
         1:       io.out_ready = ($urandom_range(0, 3) != 0);
         default: io.out_ready = 1'b0;
      endcase
      @(posedge clk);
      #1;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst !== 1'b0) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", io.out_valid, 1'b1);
            check("hold_sum", io.out_sum, prev_sum);
            check("hold_cout", io.out_cout, prev_cout);
            check("hold_ovf", io.out_ovf, prev_ovf);
         end
         if (io.out_valid === 1'b1 && io.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_beat: got sum 0x%0h, expected no output", io.out_sum);
            end else begin
               e = sb.pop_front();
               check("sum", io.out_sum, e.sum);
               check("cout", io.out_cout, e.cout);
               check("ovf", io.out_ovf, e.ovf);
            end
         end
         prev_hold = (io.out_valid === 1'b1) && (io.out_ready === 1'b0);
         prev_sum  = io.out_sum;
         prev_cout = io.out_cout;
         prev_ovf  = io.out_ovf;
      end
   end

   // Reference: plain integer arithmetic, chain carry = cout of previous issued beat.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input logic chain, input bit use_c = 1'b0,
                       input logic [W-1:0] es = '0, input logic ec = 1'b0,
                       input logic eo = 1'b0);
      exp_t       e;
      logic [W-1:0] bb;
      logic       ci;
      logic [W:0] full;
      int         n;
      bit         ok;
      @(negedge clk);
      io.in_valid = 1'b1;
      io.in_a     = a;
      io.in_b     = b;
      io.in_cin   = cin;
      io.in_sub   = sub;
      io.in_chain = chain;
      n  = 0;
      ok = 1'b1;
      while (io.in_ready !== 1'b1) begin
         stall_seen = 1'b1;
         @(negedge clk);
         n++;
         if (n > 200) begin
            n_vec++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=%b, expected 1 within 200 cycles", io.in_ready);
            ok = 1'b0;
            break;
         end
      end
      if (ok) begin
         bb     = sub ? ~b : b;
         ci     = chain ? chain_m : (sub ? 1'b1 : cin);
         full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
         e.sum  = full[W-1:0];
         e.cout = full[W];
         e.ovf  = (a[W-1] == bb[W-1]) && (e.sum[W-1] != a[W-1]);
         if (use_c) begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
         end
         chain_m = e.cout;
         sb.push_back(e);
         @(posedge clk);
      end
      #1;
      io.in_valid = 1'b0;
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(posedge clk);
         n++;
      end
      check("drain_pending", sb.size(), 0);
   endtask

   initial begin
      #500000;
      n_vec++;
      n_fail++;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      rst         = 1'b1;
      io.in_valid = 1'b0;
      io.in_a     = '0;
      io.in_b     = '0;
      io.in_cin   = 1'b0;
      io.in_sub   = 1'b0;
      io.in_chain = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", io.out_valid, 1'b0);
      rst = 1'b0;
      #1;
      check("reset_in_ready", io.in_ready, 1'b1);

      // Add with overflow; out_valid appears on the S-th edge after the accept cycle.
      send(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
      for (int i = 1; i < S; i++) begin
         check("latency_early", io.out_valid, 1'b0);
         @(posedge clk);
         #1;
      end
      check("latency_valid", io.out_valid, 1'b1);
      drain(20);

      send(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
      send(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
      drain(20);

      send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      send(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
      send(8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 1'b1, 8'h47, 1'b0, 1'b0);
      drain(20);

      // Backpressure: consumer held off while four beats are offered.
      rdy_mode = 2;
      @(posedge clk);
      #2;
      stall_seen = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               send(W'(i), 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, W'(8'h10 + i), 1'b0, 1'b0);
            end
         end
         begin
            repeat (6) @(posedge clk);
            rdy_mode = 0;
         end
      join
      check("in_ready_dropped", stall_seen, 1'b1);
      drain(40);

      // Reset with chain carry set and two beats in flight.
      send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      drain(20);
      rdy_mode = 2;
      @(posedge clk);
      #2;
      send(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
      send(8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midreset_out_valid", io.out_valid, 1'b0);
      sb.delete();
      chain_m = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rdy_mode = 0;
      send(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      drain(20);

      // Random operands, modes and consumer stalls.
      rdy_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 7) == 0) @(posedge clk);
      end
      drain(2000);
      rdy_mode = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
